uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver grand module. Captures each completed byte together with its parity-error and framing-error status when the receiver raises its done flag. Holds up to DEPTH entries and presents them to the host or bus side through a first-word-fall-through valid/ready read port. Reports fill level, full/empty status, a programmable almost-full flag and a sticky overrun flag.

---
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with status capture, FWFT read port and overrun flag
// Optional feature macro: RX_FIFO_DROP_ERR_EN (discard errored bytes, report via err_dropped)
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_parity_err,
  input  logic              rx_frame_err,
  input  logic              rd_ready,
  input  logic              ovr_clr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_parity_err,
  output logic              rd_frame_err,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun
`ifdef RX_FIFO_DROP_ERR_EN
  ,
  output logic              err_dropped
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

  // Each entry packs {frame_err, parity_err, data}
  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              done_q;
  logic              overrun_q;

  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              do_push;
  logic              ovr_set;
  logic [9:0]        head;

  assign push_req = rx_done & ~done_q;

`ifdef RX_FIFO_DROP_ERR_EN
  logic has_err;
  logic err_set;
  logic err_dropped_q;
  assign has_err     = rx_parity_err | rx_frame_err;
  assign push_ok     = push_req & ~has_err;
  assign err_set     = push_req & has_err;
  assign err_dropped = err_dropped_q;
`else
  assign push_ok = push_req;
`endif

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AFULL_CNT);
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign rd_valid    = ~empty;

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign pop     = rd_valid & rd_ready;
  assign do_push = push_ok & (~full | pop);
  assign ovr_set = push_ok & full & ~pop;

  // Head entry is shown only while valid so a reset FIFO reads zeros
  assign head          = mem[rd_ptr];
  assign rd_data       = rd_valid ? head[7:0] : 8'h00;
  assign rd_parity_err = rd_valid & head[8];
  assign rd_frame_err  = rd_valid & head[9];

  // Storage array write; contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {rx_frame_err, rx_parity_err, rx_data};
    end
  end

  // Rising-edge detector for the receiver done level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done;
    end
  end

  // Pointer advance; power-of-two depth lets the natural wrap act as modulo
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy counter; simultaneous push and pop cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overrun; a new loss in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

`ifdef RX_FIFO_DROP_ERR_EN
  // Sticky errored-byte discard flag, shares the overrun clear pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_dropped_q <= 1'b0;
    end else if (err_set) begin
      err_dropped_q <= 1'b1;
    end else if (ovr_clr) begin
      err_dropped_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_parity_err = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic       rd_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overrun;
`ifdef RX_FIFO_DROP_ERR_EN
  logic       err_dropped;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: expected contents, sticky flags, edge history
  logic [9:0] mq[$];
  logic       ovr_m = 1'b0;
  logic       errd_m = 1'b0;
  logic       dq_m = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rd_ready(rd_ready), .ovr_clr(ovr_clr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overrun(overrun)
`ifdef RX_FIFO_DROP_ERR_EN
    , .err_dropped(err_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction per clock, written from the rules
  task automatic model_step();
    logic push;
    logic pop;
    logic drop_err;
    if (!rst) begin
      mq.delete();
      ovr_m = 1'b0;
      errd_m = 1'b0;
      dq_m = 1'b0;
    end else begin
      push = rx_done && !dq_m;
      dq_m = rx_done;
      pop = (mq.size() != 0) && rd_ready;
      drop_err = 1'b0;
`ifdef RX_FIFO_DROP_ERR_EN
      if (push && (rx_parity_err || rx_frame_err)) begin
        push = 1'b0;
        drop_err = 1'b1;
      end
`endif
      if (ovr_clr) begin
        ovr_m = 1'b0;
        errd_m = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({rx_frame_err, rx_parity_err, rx_data});
        else ovr_m = 1'b1;
      end
      if (drop_err) errd_m = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Monitor: compare DUT status and presented head entry against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_valid", rd_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("almost_full", almost_full, mq.size() >= AFULL);
      chk("overrun", overrun, ovr_m);
`ifdef RX_FIFO_DROP_ERR_EN
      chk("err_dropped", err_dropped, errd_m);
`endif
      if (rd_valid) begin
        chk("head_entry", {rd_frame_err, rd_parity_err, rd_data}, mq[0]);
      end else begin
        chk("idle_head_zero", {rd_frame_err, rd_parity_err, rd_data}, 10'h000);
      end
    end
  end

  task automatic step(input logic d, input logic [7:0] b, input logic pe, input logic fe,
                      input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    rx_done = d;
    rx_data = b;
    rx_parity_err = pe;
    rx_frame_err = fe;
    rd_ready = rdy;
    ovr_clr = clr;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic pe, input logic fe);
    step(1'b1, b, pe, fe, 1'b0, 1'b0);
    step(1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b1;

    // Single byte, one cycle of latency, then one read
    write_byte(8'hA5, 1'b0, 1'b0);
    chk("a5_valid", rd_valid, 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_count", count, 1);
    drain(1);
    chk("a5_empty", empty, 1);

    // Held done level produces exactly one write
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_count", count, 1);
    drain(1);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_afull", almost_full, 1);
    write_byte(8'hFF, 1'b0, 1'b0);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 16);
    drain(16);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_clr", overrun, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hE7, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fullpp_count", count, 16);
    chk("fullpp_ovr", overrun, 0);
    drain(16);

    // Error status bytes
    write_byte(8'h55, 1'b1, 1'b0);
    write_byte(8'h66, 1'b0, 1'b1);
`ifdef RX_FIFO_DROP_ERR_EN
    chk("errdrop_count", count, 0);
    chk("errdrop_flag", err_dropped, 1);
`else
    chk("perr_entry", {rd_frame_err, rd_parity_err, rd_data}, 10'h155);
    drain(1);
    chk("ferr_entry", {rd_frame_err, rd_parity_err, rd_data}, 10'h266);
`endif
    drain(2);

    // Randomized traffic with wrap, occasional clears and biased fill phases
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), rdy, ($urandom_range(0, 40) == 0));
    end

    // Mid-stream reset takes effect without a clock edge
    for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", rd_valid, 0);
    rx_done = 1'b0;
    rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    write_byte(8'h5A, 1'b0, 1'b0);
    chk("post_rst_data", rd_data, 8'h5A);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
